// File: rtl/z80_bus_arbiter_if.sv
// Purpose : bundles the DMA/Z80 handshake signals seen by z80_bus_arbiter.
// Latency : n/a (wiring only).
// Backpressure: n/a. Modports: master = arbiter (drives nBUSRQ, dma_grant,
//   hold_timeout, ack_error); slave = environment (drives dma_req, dma_done, nBUSAK).
interface z80_bus_arbiter_if;
  logic dma_req;       // DMA wants the bus
  logic dma_done;      // single-cycle end-of-transfer pulse
  logic nBUSAK;        // Z80 bus acknowledge, active-low
  logic nBUSRQ;        // Z80 bus request, active-low
  logic dma_grant;     // DMA owns the bus
  logic hold_timeout;  // one-cycle pulse: grant revoked by hold limit
  logic ack_error;     // one-cycle pulse: acknowledge with no request outstanding

  modport master (
    input  dma_req, dma_done, nBUSAK,
    output nBUSRQ, dma_grant, hold_timeout, ack_error
  );

  modport slave (
    output dma_req, dma_done, nBUSAK,
    input  nBUSRQ, dma_grant, hold_timeout, ack_error
  );
endinterface

// File: rtl/z80_bus_arbiter.sv
// Purpose : arbitrates the Z80 bus between the CPU and one DMA requester,
//   bounding DMA hold time (MAX_HOLD) and guaranteeing CPU gaps (MIN_CPU).
// Latency : every output is registered; inputs affect outputs one CLK later.
// Backpressure: the DMA waits in REQUEST until the Z80 acknowledges; no timeout
//   while waiting for the Z80 to hand the bus back.
// Ports   : CLK, nRESET (async active-low), bus (z80_bus_arbiter_if.master).
module z80_bus_arbiter #(
  parameter int MAX_HOLD = 64,  // 1..255
  parameter int MIN_CPU  = 4    // 1..255
) (
  input  logic               CLK,
  input  logic               nRESET,
  z80_bus_arbiter_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQUEST = 3'd1,
    GRANTED = 3'd2,
    RELEASE = 3'd3,
    GAP     = 3'd4
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(MIN_CPU);

  state_t     state_q, state_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic       nbusrq_q, nbusrq_d;
  logic       grant_q, grant_d;
  logic       timeout_q, timeout_d;
  logic       ack_err_q, ack_err_d;
  logic       expired;

  assign expired = (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    timeout_d  = 1'b0;
    ack_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        ack_err_d = ~bus.nBUSAK;
        if (bus.dma_req) state_d = REQUEST;
      end
      REQUEST: begin
        // Acknowledge beats a simultaneous withdrawal: the Z80 has already
        // floated its bus, so take it and let GRANTED release immediately.
        if (!bus.nBUSAK) begin
          state_d    = GRANTED;
          hold_cnt_d = 8'd0;
        end else if (!bus.dma_req) begin
          state_d = IDLE;
        end
      end
      GRANTED: begin
        hold_cnt_d = hold_cnt_q + 8'd1;
        if (bus.dma_done || !bus.dma_req || expired) begin
          state_d    = RELEASE;
          hold_cnt_d = 8'd0;
          // Only flag a timeout when expiry is the sole reason for release.
          timeout_d  = expired && !bus.dma_done && bus.dma_req;
        end
      end
      RELEASE: begin
        if (bus.nBUSAK) begin
          state_d   = GAP;
          gap_cnt_d = GAP_LOAD;
        end
      end
      GAP: begin
        ack_err_d = ~bus.nBUSAK;
        if (gap_cnt_q <= 8'd1) begin
          state_d   = IDLE;
          gap_cnt_d = 8'd0;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = 8'd0;
        gap_cnt_d  = 8'd0;
      end
    endcase

    // Outputs are decoded from the next state so they register alongside it;
    // grant can only be high in GRANTED, where nBUSRQ is also low.
    nbusrq_d = !((state_d == REQUEST) || (state_d == GRANTED));
    grant_d  = (state_d == GRANTED);
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= IDLE;
      hold_cnt_q <= 8'd0;
      gap_cnt_q  <= 8'd0;
      nbusrq_q   <= 1'b1;
      grant_q    <= 1'b0;
      timeout_q  <= 1'b0;
      ack_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      nbusrq_q   <= nbusrq_d;
      grant_q    <= grant_d;
      timeout_q  <= timeout_d;
      ack_err_q  <= ack_err_d;
    end
  end

  assign bus.nBUSRQ       = nbusrq_q;
  assign bus.dma_grant    = grant_q;
  assign bus.hold_timeout = timeout_q;
  assign bus.ack_error    = ack_err_q;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Purpose : directed self-checking bench for z80_bus_arbiter (MAX_HOLD=8, MIN_CPU=4).
// Latency : outputs sampled 1 time unit after each rising CLK; inputs driven then.
// Backpressure: n/a; the Z80 acknowledge is scripted per cycle.
module tb_z80_bus_arbiter;
  logic CLK;
  logic nRESET;
  int   total;
  int   passed;
  int   fails;

  z80_bus_arbiter_if bus ();

  z80_bus_arbiter #(
    .MAX_HOLD (8),
    .MIN_CPU  (4)
  ) dut (
    .CLK    (CLK),
    .nRESET (nRESET),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string t, input int c, input logic rq, input logic g,
                      input logic to, input logic ae);
    chk($sformatf("%s.c%0d.nBUSRQ", t, c), bus.nBUSRQ, rq);
    chk($sformatf("%s.c%0d.dma_grant", t, c), bus.dma_grant, g);
    chk($sformatf("%s.c%0d.hold_timeout", t, c), bus.hold_timeout, to);
    chk($sformatf("%s.c%0d.ack_error", t, c), bus.ack_error, ae);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    fails  = 0;
    bus.dma_req  = 1'b0;
    bus.dma_done = 1'b0;
    bus.nBUSAK   = 1'b1;
    nRESET       = 1'b1;
    #1 nRESET    = 1'b0;
    #1;
    // Reset values before any clock edge.
    chk4("reset", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    nRESET = 1'b1;
    bus.dma_req = 1'b0;
    chk4("rst_release", 0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Basic grant: req at 0, ack from 3, done at 10.
    for (int c = 0; c <= 18; c++) begin
      chk4("basic", c, !(c >= 1 && c <= 10), (c >= 4 && c <= 10), 1'b0, 1'b0);
      bus.dma_req  = (c <= 10);
      bus.dma_done = (c == 10);
      bus.nBUSAK   = !(c >= 3 && c <= 11);
      tick();
    end
    bus.dma_done = 1'b0;

    // Timeout at MAX_HOLD=8, then CPU gap of MIN_CPU=4 before re-request.
    for (int c = 0; c <= 21; c++) begin
      chk4("timeout", c, !((c >= 1 && c <= 10) || c == 19), (c >= 3 && c <= 10),
           (c == 11), 1'b0);
      bus.dma_req = (c <= 18);
      bus.nBUSAK  = !(c >= 2 && c <= 12);
      tick();
    end

    // Withdraw before acknowledge.
    for (int c = 0; c <= 5; c++) begin
      chk4("withdraw", c, !(c >= 1 && c <= 3), 1'b0, 1'b0, 1'b0);
      bus.dma_req = (c <= 2);
      bus.nBUSAK  = 1'b1;
      tick();
    end

    // Spurious acknowledge in IDLE.
    for (int c = 0; c <= 5; c++) begin
      chk4("spurious", c, 1'b1, 1'b0, 1'b0, (c >= 1 && c <= 3));
      bus.dma_req = 1'b0;
      bus.nBUSAK  = !(c <= 2);
      tick();
    end

    // dma_done in REQUEST is discarded; done coincident with expiry gives no timeout.
    for (int c = 0; c <= 16; c++) begin
      chk4("done_expiry", c, !(c >= 1 && c <= 9), (c >= 2 && c <= 9), 1'b0, 1'b0);
      bus.dma_req  = (c <= 9);
      bus.dma_done = (c == 1 || c == 9);
      bus.nBUSAK   = !(c >= 1 && c <= 9);
      tick();
    end
    bus.dma_done = 1'b0;

    // Acknowledge and withdrawal in the same cycle: one-cycle grant.
    for (int c = 0; c <= 10; c++) begin
      chk4("ack_withdraw", c, !(c == 1 || c == 2), (c == 2), 1'b0, 1'b0);
      bus.dma_req = (c == 0);
      bus.nBUSAK  = !(c >= 1 && c <= 3);
      tick();
    end

    // Reset mid-grant.
    for (int c = 0; c <= 3; c++) begin
      chk4("rst_grant", c, !(c >= 1), (c >= 2), 1'b0, 1'b0);
      bus.dma_req = 1'b1;
      bus.nBUSAK  = !(c >= 1);
      tick();
    end
    chk("rst_grant.pre.dma_grant", bus.dma_grant, 1'b1);
    nRESET     = 1'b0;
    bus.nBUSAK = 1'b1;
    #1;
    chk4("rst_async", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk4("rst_hold", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    nRESET = 1'b1;
    #1;
    chk4("rst_deassert", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk4("rst_rereq", 1, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.dma_req = 1'b0;
    tick();
    chk4("rst_rereq", 2, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/z80_bus_arbiter.md
Z80_BUS_ARBITER -- requirements
Module: z80_bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 64: maximum consecutive cycles dma_grant may stay high, legal range 1..255.
REQ-002 SHALL have parameter MIN_CPU, default 4: minimum cycles the CPU owns the bus between two DMA grants, legal range 1..255.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port nRESET, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port dma_req, input, 1 bit: the DMA requester wants the Z80 bus.
REQ-006 SHALL have port dma_done, input, 1 bit: single-cycle pulse meaning the DMA transfer is finished.
REQ-007 SHALL have port nBUSAK, input, 1 bit: bus acknowledge from the Z80 core, active-low, same clock domain.
REQ-008 SHALL have port nBUSRQ, output, 1 bit: bus request to the Z80 core, active-low.
REQ-009 SHALL have port dma_grant, output, 1 bit: the DMA owns the bus.
REQ-010 SHALL have port hold_timeout, output, 1 bit: one-cycle pulse when a grant is revoked by MAX_HOLD expiry.
REQ-011 SHALL have port ack_error, output, 1 bit: one-cycle pulse when nBUSAK is low although no request is outstanding.

Function
REQ-012 SHALL register all outputs, with no combinational path from any input to any output.
REQ-013 SHALL implement five states: IDLE, REQUEST, GRANTED, RELEASE, GAP.
REQ-014 IDLE: nBUSRQ=1, dma_grant=0; if dma_req=1, go to REQUEST and drive nBUSRQ low on the next cycle.
REQ-015 REQUEST: nBUSRQ=0, dma_grant=0.
- nBUSAK=0 sampled: go to GRANTED; dma_grant=1 from the following cycle; hold counter cleared.
- dma_req=0 with nBUSAK=1: withdraw, return to IDLE, nBUSRQ=1 next cycle.
- dma_req=0 and nBUSAK=0 in the same cycle: acknowledge wins; go to GRANTED, which releases on its first cycle per REQ-017.
REQ-016 GRANTED: nBUSRQ=0, dma_grant=1; 8-bit hold counter increments once per GRANTED cycle.
REQ-017 GRANTED release: on dma_done=1, dma_req=0, or hold counter = MAX_HOLD-1, go to RELEASE; dma_grant and nBUSRQ both deassert on the next cycle.
- dma_grant is therefore high for at most MAX_HOLD cycles.
REQ-018 SHALL pulse hold_timeout only when release is caused solely by expiry (dma_done=0 and dma_req=1 on the expiry cycle).
- Simultaneous dma_done and expiry: no pulse.
REQ-019 RELEASE: nBUSRQ=1, dma_grant=0; wait for nBUSAK=1, then go to GAP loading the gap counter with MIN_CPU.
- No timeout applies in RELEASE; the Z80 returns the bus at its next machine cycle.
REQ-020 GAP: nBUSRQ=1, dma_grant=0; the gap counter decrements each cycle; at 1, go to IDLE.
- dma_req held high throughout yields nBUSRQ low exactly MIN_CPU+1 cycles after GAP entry.
REQ-021 SHALL pulse ack_error for each cycle nBUSAK=0 is sampled in IDLE or GAP; the state is unaffected.
REQ-022 dma_req and dma_done SHALL be ignored in RELEASE and GAP; a dma_done seen outside GRANTED SHALL be discarded.
REQ-023 dma_grant=1 SHALL imply nBUSRQ=0 on the same cycle.
REQ-024 dma_grant SHALL never rise unless nBUSAK was 0 on the previous cycle.

Reset
REQ-025 nRESET low SHALL immediately, without a clock edge, force: state IDLE, nBUSRQ=1, dma_grant=0, hold_timeout=0, ack_error=0, both counters 0.
REQ-026 Reset during GRANTED SHALL drop dma_grant immediately.
- After release, the first dma_req SHALL be handled from IDLE with no GAP enforced.
REQ-027 nRESET deassertion SHALL take effect at the first rising CLK edge after release; no output changes before that edge.

Verification
REQ-028 Basic grant: dma_req=1 at cycle 0; nBUSAK=0 from cycle 3; dma_done pulse at cycle 10.
- nBUSRQ low cycles 1..10; dma_grant high cycles 4..10; nBUSRQ=1 and grant=0 at cycle 11.
REQ-029 Timeout: MAX_HOLD=8; dma_req held high; nBUSAK=0 from cycle 2.
- dma_grant high exactly 8 cycles (3..10); hold_timeout pulses once; nBUSRQ=1 at cycle 11.
REQ-030 Fairness: MIN_CPU=4; dma_req held high; nBUSAK returns high 2 cycles after release.
- nBUSRQ stays 1 for 4 GAP cycles plus the IDLE cycle before reasserting.
REQ-031 Withdraw: dma_req 1 for cycles 0..2 with nBUSAK held 1.
- nBUSRQ low cycles 1..3, high from cycle 4; dma_grant never 1; ack_error never 1.
REQ-032 Reset mid-grant: nRESET low for 2 cycles while dma_grant=1.
- nBUSRQ=1 and dma_grant=0 within the reset cycle, with no clock edge required; after reset, dma_req=1 produces nBUSRQ low on the next cycle.
REQ-033 Spurious acknowledge: nBUSAK=0 for 3 cycles in IDLE with dma_req=0.
- ack_error high those 3 cycles; nBUSRQ stays 1; dma_grant stays 0.
